control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer for a small accumulator CPU: walks the
// fetch/decode/execute states and decodes every datapath strobe from them.
module control_sequencer #(
    parameter int BUS_WIDTH    = 16,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [BUS_WIDTH-1:0] INSTRUCTION,
    input  logic                 MEM_READY,
    input  logic                 CARRY_IN,
    input  logic                 ZERO_IN,
    output logic                 PC_ENABLE,
    output logic                 PC_LOAD,
    output logic                 PC_COUNT,
    output logic                 MAR_LOAD,
    output logic                 MEM_ENABLE,
    output logic                 MEM_LOAD,
    output logic                 IR_LOAD,
    output logic                 IR_ENABLE,
    output logic                 A_LOAD,
    output logic                 A_ENABLE,
    output logic                 B_LOAD,
    output logic                 ALU_ENABLE,
    output logic                 ALU_SUB,
    output logic                 OUT_LOAD,
    output logic [2:0]           STEP,
    output logic                 HALTED,
    output logic                 FLAG_C,
    output logic                 FLAG_Z
);

    typedef enum logic [2:0] {
        FETCH_ADDR = 3'd0,
        FETCH_MEM  = 3'd1,
        DECODE     = 3'd2,
        EXEC_ADDR  = 3'd3,
        EXEC_MEM   = 3'd4,
        EXEC_ALU   = 3'd5,
        HALT       = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } op_t;

    state_t                  state;
    state_t                  next_state;
    op_t                     op;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    flag_c;
    logic                    flag_z;

    logic pc_enable, pc_load, pc_count, mar_load, mem_enable, mem_load;
    logic ir_load, ir_enable, a_load, a_enable, b_load;
    logic alu_enable, alu_sub, out_load;

    // The operand field goes straight from the instruction register to the bus.
    logic unused_operand;
    assign unused_operand = ^INSTRUCTION[BUS_WIDTH-OPCODE_WIDTH-1:0];

    assign opcode = INSTRUCTION[BUS_WIDTH-1 -: OPCODE_WIDTH];

    always_comb begin
        op = OP_NOP;
        case (opcode)
            OPCODE_WIDTH'(4'h1): op = OP_LDA;
            OPCODE_WIDTH'(4'h2): op = OP_ADD;
            OPCODE_WIDTH'(4'h3): op = OP_SUB;
            OPCODE_WIDTH'(4'h4): op = OP_STA;
            OPCODE_WIDTH'(4'h5): op = OP_LDI;
            OPCODE_WIDTH'(4'h6): op = OP_JMP;
            OPCODE_WIDTH'(4'h7): op = OP_JC;
            OPCODE_WIDTH'(4'h8): op = OP_JZ;
            OPCODE_WIDTH'(4'hE): op = OP_OUT;
            OPCODE_WIDTH'(4'hF): op = OP_HLT;
            default:             op = OP_NOP;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state  <= FETCH_ADDR;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            state <= next_state;
            if (state == EXEC_ALU) begin
                flag_c <= CARRY_IN;
                flag_z <= ZERO_IN;
            end
        end
    end

    always_comb begin
        next_state = state;
        pc_enable  = 1'b0;
        pc_load    = 1'b0;
        pc_count   = 1'b0;
        mar_load   = 1'b0;
        mem_enable = 1'b0;
        mem_load   = 1'b0;
        ir_load    = 1'b0;
        ir_enable  = 1'b0;
        a_load     = 1'b0;
        a_enable   = 1'b0;
        b_load     = 1'b0;
        alu_enable = 1'b0;
        alu_sub    = 1'b0;
        out_load   = 1'b0;

        case (state)
            FETCH_ADDR: begin
                pc_enable  = 1'b1;
                mar_load   = 1'b1;
                next_state = FETCH_MEM;
            end
            FETCH_MEM: begin
                mem_enable = 1'b1;
                ir_load    = 1'b1;
                if (MEM_READY) begin
                    pc_count   = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                next_state = FETCH_ADDR;
                case (op)
                    OP_LDI: begin
                        ir_enable = 1'b1;
                        a_load    = 1'b1;
                    end
                    OP_JMP: begin
                        ir_enable = 1'b1;
                        pc_load   = 1'b1;
                    end
                    OP_JC: begin
                        ir_enable = flag_c;
                        pc_load   = flag_c;
                    end
                    OP_JZ: begin
                        ir_enable = flag_z;
                        pc_load   = flag_z;
                    end
                    OP_OUT: begin
                        a_enable = 1'b1;
                        out_load = 1'b1;
                    end
                    OP_HLT:                        next_state = HALT;
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: next_state = EXEC_ADDR;
                    default: ;
                endcase
            end
            EXEC_ADDR: begin
                ir_enable  = 1'b1;
                mar_load   = 1'b1;
                next_state = EXEC_MEM;
            end
            EXEC_MEM: begin
                // Strobes depend only on the opcode so they hold steady while waiting.
                case (op)
                    OP_LDA: begin
                        mem_enable = 1'b1;
                        a_load     = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        mem_enable = 1'b1;
                        b_load     = 1'b1;
                    end
                    OP_STA: begin
                        a_enable = 1'b1;
                        mem_load = 1'b1;
                    end
                    default: ;
                endcase
                if (MEM_READY) begin
                    if (op == OP_ADD || op == OP_SUB) next_state = EXEC_ALU;
                    else                              next_state = FETCH_ADDR;
                end
            end
            EXEC_ALU: begin
                alu_enable = 1'b1;
                a_load     = 1'b1;
                alu_sub    = (op == OP_SUB);
                next_state = FETCH_ADDR;
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH_ADDR;
        endcase
    end

    // Reset overrides the decode so nothing strobes while it is held.
    assign PC_ENABLE  = pc_enable  & ~RESET;
    assign PC_LOAD    = pc_load    & ~RESET;
    assign PC_COUNT   = pc_count   & ~RESET;
    assign MAR_LOAD   = mar_load   & ~RESET;
    assign MEM_ENABLE = mem_enable & ~RESET;
    assign MEM_LOAD   = mem_load   & ~RESET;
    assign IR_LOAD    = ir_load    & ~RESET;
    assign IR_ENABLE  = ir_enable  & ~RESET;
    assign A_LOAD     = a_load     & ~RESET;
    assign A_ENABLE   = a_enable   & ~RESET;
    assign B_LOAD     = b_load     & ~RESET;
    assign ALU_ENABLE = alu_enable & ~RESET;
    assign ALU_SUB    = alu_sub    & ~RESET;
    assign OUT_LOAD   = out_load   & ~RESET;
    assign HALTED     = (state == HALT) & ~RESET;
    assign STEP       = state;
    assign FLAG_C     = flag_c;
    assign FLAG_Z     = flag_z;

endmodule
